// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared definitions for the two-requester SPI Mode-0 master:
//   - state_t : controller FSM states (IDLE/SETUP/SHI/SLO/GAP)
//   - SPI_W   : SPI frame width in bits
//   - NREQ    : number of requesters
//   - onehot(): requester index -> one-hot grant vector
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

  localparam int SPI_W = 8;
  localparam int NREQ  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHI   = 3'd2,
    SLO   = 3'd3,
    GAP   = 3'd4
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/spi_master_arb_if.sv
// -----------------------------------------------------------------------------
// spi_master_arb_if
// Bundles the requester handshake and the SPI pins of spi_master_arb.
//   req/wdata          : requester -> master
//   gnt/busy/done/...  : master -> requesters
//   CS/SCLK/MOSI       : master -> SPI slave
//   MISO               : SPI slave -> master
// Modports:
//   master : the SPI master block (drives grants, results and SPI pins)
//   slave  : the environment (requesters plus the SPI slave)
// -----------------------------------------------------------------------------
interface spi_master_arb_if;
  import spi_ctrl_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*SPI_W-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic                  done_id;
  logic [SPI_W-1:0]      rdata;
  logic                  CS;
  logic                  SCLK;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  req, wdata, MISO,
    output gnt, busy, done, done_id, rdata, CS, SCLK, MOSI
  );

  modport slave (
    output req, wdata, MISO,
    input  gnt, busy, done, done_id, rdata, CS, SCLK, MOSI
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational two-way round-robin pick. The parent registers the winner
// into its "last" pointer when the grant is taken.
// Ports:
//   i_req    : per-requester request
//   i_last   : index of the most recently granted requester
//   o_valid  : at least one request is pending
//   o_winner : index of the requester to grant
// -----------------------------------------------------------------------------
module spi_rr_arbiter
  import spi_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_last,
  output logic            o_valid,
  output logic            o_winner
);

  assign o_valid = |i_req;

  // Contention goes to whoever was not served last; otherwise the single
  // active requester wins (index 0 when nothing is pending, unused then).
  always_comb begin
    o_winner = i_req[1];
    if (&i_req) begin
      o_winner = ~i_last;
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// -----------------------------------------------------------------------------
// spi_master_arb
// Two-requester SPI Mode-0 master. Arbitrates round-robin, then runs one
// full-duplex 8-bit frame (MSB first) per grant and returns the received
// byte to the granted requester with a one-cycle done pulse.
// Parameters:
//   CLK_DIV : clk cycles per SCLK half-period (>=1)
//   CS_GAP  : clk cycles CS stays high between frames (>=1)
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : synchronous active-high reset (aborts any frame in flight)
//   bus   : requester handshake and SPI pins (spi_master_arb_if.master)
// Build option:
//   SPI_LOOPBACK_EN : when defined, the receive path samples MOSI instead of
//                     the MISO pin so rdata echoes the transmitted byte.
// -----------------------------------------------------------------------------
module spi_master_arb
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic clk,
  input  logic reset,
  spi_master_arb_if.master bus
);

  // One counter serves both the SCLK half-periods and the CS gap.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit, w_bit_next;
  logic [SPI_W-2:0] r_shift, w_shift_next;   // bits still to send after MOSI
  logic [SPI_W-1:0] r_rx, w_rx_next;
  logic             r_last, w_last_next;
  logic [NREQ-1:0]  r_gnt, w_gnt_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_done_id, w_done_id_next;
  logic [SPI_W-1:0] r_rdata, w_rdata_next;
  logic             r_cs, w_cs_next;
  logic             r_sclk, w_sclk_next;
  logic             r_mosi, w_mosi_next;

  logic             w_arb_valid;
  logic             w_winner;
  logic             w_grant;
  logic             w_sample;
  logic             w_div_end;
  logic             w_gap_end;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [SPI_W-1:0] w_wbyte [NREQ];

  // Split the packed write bus into one byte per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_wbyte
      assign w_wbyte[gi] = bus.wdata[gi*SPI_W +: SPI_W];
    end
  endgenerate

  spi_rr_arbiter u_arb (
    .i_req    (bus.req),
    .i_last   (r_last),
    .o_valid  (w_arb_valid),
    .o_winner (w_winner)
  );

`ifdef SPI_LOOPBACK_EN
  assign w_sample = r_mosi;
`else
  assign w_sample = bus.MISO;
`endif

  assign w_div_end = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_gap_end = (r_cnt == CNT_W'(CS_GAP - 1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_last    <= 1'b1;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_rdata   <= '0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit     <= w_bit_next;
      r_shift   <= w_shift_next;
      r_rx      <= w_rx_next;
      r_last    <= w_last_next;
      r_gnt     <= w_gnt_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_done_id <= w_done_id_next;
      r_rdata   <= w_rdata_next;
      r_cs      <= w_cs_next;
      r_sclk    <= w_sclk_next;
      r_mosi    <= w_mosi_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_next     = r_bit;
    w_shift_next   = r_shift;
    w_rx_next      = r_rx;
    w_last_next    = r_last;
    w_gnt_next     = r_gnt;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_done_id_next = r_done_id;
    w_rdata_next   = r_rdata;
    w_cs_next      = r_cs;
    w_sclk_next    = r_sclk;
    w_mosi_next    = r_mosi;
    w_grant        = 1'b0;

    case (r_state)
      IDLE: begin
        w_grant = w_arb_valid;
      end

      SETUP: begin
        if (w_div_end) begin
          w_state_next = SHI;
          w_sclk_next  = 1'b1;
          w_rx_next    = {r_rx[SPI_W-2:0], w_sample};
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      SHI: begin
        if (w_div_end) begin
          w_state_next = SLO;
          w_sclk_next  = 1'b0;
          w_cnt_next   = '0;
          // Present the next bit on the falling edge; the last bit stays.
          if (r_bit < 3'd7) begin
            w_mosi_next  = r_shift[SPI_W-2];
            w_shift_next = {r_shift[SPI_W-3:0], 1'b0};
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      SLO: begin
        if (w_div_end) begin
          w_cnt_next = '0;
          if (r_bit < 3'd7) begin
            w_bit_next   = r_bit + 3'd1;
            w_state_next = SHI;
            w_sclk_next  = 1'b1;
            w_rx_next    = {r_rx[SPI_W-2:0], w_sample};
          end else begin
            // Low phase after the 8th rising edge: close the frame.
            w_state_next   = GAP;
            w_cs_next      = 1'b1;
            w_gnt_next     = '0;
            w_mosi_next    = 1'b0;
            w_done_next    = 1'b1;
            w_done_id_next = r_last;
            w_rdata_next   = r_rx;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      GAP: begin
        if (w_gap_end) begin
          // A pending request is granted on the same edge that would
          // return to IDLE, so CS stays high for exactly CS_GAP cycles.
          if (w_arb_valid) begin
            w_grant = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_grant) begin
      w_state_next = SETUP;
      w_gnt_next   = onehot(w_winner);
      w_busy_next  = 1'b1;
      w_cs_next    = 1'b0;
      w_sclk_next  = 1'b0;
      w_mosi_next  = w_wbyte[w_winner][SPI_W-1];
      w_shift_next = w_wbyte[w_winner][SPI_W-2:0];
      w_last_next  = w_winner;
      w_cnt_next   = '0;
      w_bit_next   = '0;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.rdata   = r_rdata;
  assign bus.CS      = r_cs;
  assign bus.SCLK    = r_sclk;
  assign bus.MOSI    = r_mosi;

endmodule

// File: tb/tb_spi_master_arb.sv
// -----------------------------------------------------------------------------
// tb_spi_master_arb
// Directed bench for spi_master_arb. Instance A uses CLK_DIV=2/CS_GAP=2,
// instance B uses CLK_DIV=1/CS_GAP=1. Each has a Mode-0 slave model that
// shifts a byte out MSB first, changing MISO on SCLK falling edges.
// Build option SPI_LOOPBACK_EN switches the expected rdata to the sent byte.
// -----------------------------------------------------------------------------
module tb_spi_master_arb;

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_master_arb_if bif_a ();
  spi_master_arb_if bif_b ();

  spi_master_arb #(.CLK_DIV(2), .CS_GAP(2)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bif_a)
  );

  spi_master_arb #(.CLK_DIV(1), .CS_GAP(1)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bif_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %-20s got=0x%0h want=0x%0h", tag, act, exp);
    end else begin
      $display("ok   %-20s val=0x%0h", tag, act);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] slave_byte, input logic [7:0] tx);
    return LOOPBACK ? tx : slave_byte;
  endfunction

  // ---------------- slave models ----------------
  logic [7:0] slv_a = 8'h3C;
  logic [7:0] slv_b = 8'h5A;
  logic [3:0] idx_a = 4'd0;
  logic [3:0] idx_b = 4'd0;

  always @(negedge bif_a.SCLK or posedge bif_a.CS) begin
    if (bif_a.CS) idx_a <= 4'd0;
    else          idx_a <= idx_a + 4'd1;
  end
  always @(negedge bif_b.SCLK or posedge bif_b.CS) begin
    if (bif_b.CS) idx_b <= 4'd0;
    else          idx_b <= idx_b + 4'd1;
  end
  assign bif_a.MISO = (idx_a < 4'd8) ? slv_a[3'd7 - idx_a[2:0]] : 1'b0;
  assign bif_b.MISO = (idx_b < 4'd8) ? slv_b[3'd7 - idx_b[2:0]] : 1'b0;

  // ---------------- monitors (pre-edge values at posedge) ----------------
  logic       prev_cs_a = 1'b1, prev_sclk_a = 1'b0;
  logic [1:0] prev_gnt_a = 2'b00;
  int         low_a = 0, high_a = 0, last_low_a = 0, last_high_a = 0;
  int         sclk_na = 0, done_na = 0, gnt_n = 0;
  logic [7:0] mosi_cap_a = 8'h00;
  logic       gnt_log [32];
  int         low_b = 0, high_b = 0, last_low_b = 0, last_high_b = 0;

  always @(posedge clk) begin
    prev_cs_a   <= bif_a.CS;
    prev_sclk_a <= bif_a.SCLK;
    prev_gnt_a  <= bif_a.gnt;
    if (bif_a.CS === 1'b0) low_a <= low_a + 1;
    else if (low_a != 0) begin last_low_a <= low_a; low_a <= 0; end
    if (bif_a.CS === 1'b1) high_a <= high_a + 1;
    else if (high_a != 0) begin last_high_a <= high_a; high_a <= 0; end
    if (bif_a.CS === 1'b0 && prev_cs_a) sclk_na <= 0;
    else if (bif_a.SCLK === 1'b1 && !prev_sclk_a) begin
      sclk_na    <= sclk_na + 1;
      mosi_cap_a <= {mosi_cap_a[6:0], bif_a.MOSI};
    end
    if (bif_a.done === 1'b1) done_na <= done_na + 1;
    if (bif_a.gnt !== 2'b00 && bif_a.gnt !== 2'bxx && prev_gnt_a === 2'b00 && gnt_n < 32) begin
      gnt_log[gnt_n] <= bif_a.gnt[1];
      gnt_n          <= gnt_n + 1;
    end
  end

  always @(posedge clk) begin
    if (bif_b.CS === 1'b0) low_b <= low_b + 1;
    else if (low_b != 0) begin last_low_b <= low_b; low_b <= 0; end
    if (bif_b.CS === 1'b1) high_b <= high_b + 1;
    else if (high_b != 0) begin last_high_b <= high_b; high_b <= 0; end
  end

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif_a.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bif_b.done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    bit         hit;
    int         dn;
    int         g0;
    logic [7:0] tbl [5];
    tbl[0] = 8'h5A; tbl[1] = 8'h81; tbl[2] = 8'hFF; tbl[3] = 8'h00; tbl[4] = 8'h3C;

    bif_a.req = 2'b00; bif_a.wdata = 16'h0000;
    bif_b.req = 2'b00; bif_b.wdata = 16'hC300;
    slv_b = tbl[0];

    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_cs",      {31'd0, bif_a.CS},      32'd1);
    check("rst_sclk",    {31'd0, bif_a.SCLK},    32'd0);
    check("rst_mosi",    {31'd0, bif_a.MOSI},    32'd0);
    check("rst_gnt",     {30'd0, bif_a.gnt},     32'd0);
    check("rst_busy",    {31'd0, bif_a.busy},    32'd0);
    check("rst_done",    {31'd0, bif_a.done},    32'd0);
    check("rst_done_id", {31'd0, bif_a.done_id}, 32'd0);
    check("rst_rdata",   {24'd0, bif_a.rdata},   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ---- single frame, req=01, wdata0=A5, slave returns 3C ----
    bif_a.wdata = 16'h00A5;
    bif_a.req   = 2'b01;
    @(negedge clk);
    check("f1_gnt",  {30'd0, bif_a.gnt},  32'd1);
    check("f1_busy", {31'd0, bif_a.busy}, 32'd1);
    check("f1_cs",   {31'd0, bif_a.CS},   32'd0);
    bif_a.wdata = 16'h00FF;   // must not disturb the frame in flight
    wait_done_a(200, ok);
    check("f1_done_seen", {31'd0, ok}, 32'd1);
    check("f1_done_id",   {31'd0, bif_a.done_id}, 32'd0);
    check("f1_rdata",     {24'd0, bif_a.rdata}, {24'd0, exp_rd(8'h3C, 8'hA5)});
    check("f1_mosi_bits", {24'd0, mosi_cap_a}, 32'h0000_00A5);
    check("f1_sclk_rises", sclk_na, 8);
    check("f1_gnt_clear", {30'd0, bif_a.gnt}, 32'd0);
    bif_a.req = 2'b00;
    @(negedge clk);
    check("f1_cs_low_len", last_low_a, 34);
    check("f1_done_1cyc",  {31'd0, bif_a.done}, 32'd0);
    repeat (10) @(negedge clk);
    check("idle_busy",  {31'd0, bif_a.busy}, 32'd0);
    check("idle_cs",    {31'd0, bif_a.CS},   32'd1);
    check("idle_sclk",  {31'd0, bif_a.SCLK}, 32'd0);
    check("idle_gnt",   {30'd0, bif_a.gnt},  32'd0);
    check("idle_ndone", done_na, 1);
    check("idle_rdata_hold", {24'd0, bif_a.rdata}, {24'd0, exp_rd(8'h3C, 8'hA5)});

    // ---- reset at the 4th SCLK high aborts the frame ----
    bif_a.wdata = 16'h5A77;
    bif_a.req   = 2'b01;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sclk_na == 4 && bif_a.gnt == 2'b01 && bif_a.SCLK) begin hit = 1'b1; break; end
    end
    check("rst_reach_4th_hi", {31'd0, hit}, 32'd1);
    dn = done_na;
    reset     = 1'b1;
    bif_a.req = 2'b10;
    @(negedge clk);
    check("abort_cs",   {31'd0, bif_a.CS},   32'd1);
    check("abort_sclk", {31'd0, bif_a.SCLK}, 32'd0);
    check("abort_gnt",  {30'd0, bif_a.gnt},  32'd0);
    check("abort_busy", {31'd0, bif_a.busy}, 32'd0);
    check("abort_done", {31'd0, bif_a.done}, 32'd0);
    reset = 1'b0;
    g0 = gnt_n;
    wait_done_a(200, ok);
    check("rel_done_seen", {31'd0, ok}, 32'd1);
    check("rel_no_abort_done", done_na, dn);
    check("rel_done_id", {31'd0, bif_a.done_id}, 32'd1);
    check("rel_rdata",   {24'd0, bif_a.rdata}, {24'd0, exp_rd(8'h3C, 8'h5A)});
    check("rel_gnt_log", {31'd0, gnt_log[g0]}, 32'd1);
    bif_a.req = 2'b00;
    repeat (5) @(negedge clk);

    // ---- both requesting: grants alternate 0,1,0,1 ----
    bif_a.wdata = 16'h2211;
    bif_a.req   = 2'b11;
    g0 = gnt_n;
    for (int k = 0; k < 4; k++) begin
      wait_done_a(200, ok);
      check($sformatf("alt%0d_done_seen", k), {31'd0, ok}, 32'd1);
      check($sformatf("alt%0d_done_id", k), {31'd0, bif_a.done_id}, k % 2);
      check($sformatf("alt%0d_rdata", k), {24'd0, bif_a.rdata},
            {24'd0, exp_rd(8'h3C, (k % 2 == 1) ? 8'h22 : 8'h11)});
      if (k >= 1) check($sformatf("alt%0d_gap_len", k), last_high_a, 2);
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("alt%0d_gnt_order", k), {31'd0, gnt_log[g0 + k]}, k % 2);
    end

    // ---- requester 0 drops req at bit 3 of its frame ----
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bif_a.gnt == 2'b01 && sclk_na == 3) begin hit = 1'b1; break; end
    end
    check("drop_reach_bit3", {31'd0, hit}, 32'd1);
    bif_a.req = 2'b10;
    dn = done_na;
    wait_done_a(200, ok);
    check("drop_done_seen", {31'd0, ok}, 32'd1);
    check("drop_done_id",   {31'd0, bif_a.done_id}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      wait_done_a(200, ok);
      check($sformatf("after_drop%0d_seen", k), {31'd0, ok}, 32'd1);
      check($sformatf("after_drop%0d_id", k), {31'd0, bif_a.done_id}, 32'd1);
    end
    check("drop_done_count", done_na, dn + 2);
    bif_a.req = 2'b00;
    repeat (8) @(negedge clk);
    check("drop_idle_busy", {31'd0, bif_a.busy}, 32'd0);

    // ---- instance B: CLK_DIV=1, CS_GAP=1, requester 1 continuous ----
    bif_b.req = 2'b10;
    for (int k = 0; k < 4; k++) begin
      wait_done_b(200, ok);
      check($sformatf("b%0d_done_seen", k), {31'd0, ok}, 32'd1);
      check($sformatf("b%0d_done_id", k), {31'd0, bif_b.done_id}, 32'd1);
      check($sformatf("b%0d_rdata", k), {24'd0, bif_b.rdata}, {24'd0, exp_rd(tbl[k], 8'hC3)});
      if (k >= 1) check($sformatf("b%0d_gap_len", k), last_high_b, 1);
      slv_b = tbl[k + 1];
      @(negedge clk);
      check($sformatf("b%0d_cs_low_len", k), last_low_b, 17);
    end
    bif_b.req = 2'b00;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_arb.md
Name: spi_master_arb

Overview:
- Two-requester SPI Mode-0 master that owns the bus to the 8-bit SPI slave.
- Arbitrates round-robin between requesters and generates CS/SCLK/MOSI from the system clock.
- Runs one full-duplex 8-bit frame per grant and returns the MISO byte to the granted requester.
- Sits between compute/memory-side requesters and the off-block SPI slave interface.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥1.
- CS_GAP, 2: clk cycles CS is held high between frames; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; hold high until own done.
- wdata  in  16  requester i byte at [8i+7:8i].
- gnt  out  2  one-hot; high for the whole frame of the granted requester.
- busy  out  1  high from grant until the gap ends.
- done  out  1  one-cycle pulse at frame end.
- done_id  out  1  requester index for done; valid with done.
- rdata  out  8  received byte; valid with done, held until next done.
- CS  out  1  active-low chip select.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  master data out, MSB first.
- MISO  in  1  slave data in.

Behaviour:
- Reset values: CS=1, SCLK=0, MOSI=0, gnt=0, busy=0, done=0, done_id=0, rdata=0, state=IDLE, last=1 so requester 0 wins first.
- Reset mid-frame aborts the frame: next cycle CS=1, SCLK=0, no done pulse.
- FSM states: IDLE, SETUP, SHI, SLO, GAP. A half-period counter (0..CLK_DIV-1) and a bit counter (0..7) run inside the states.
- IDLE:
  - If any req is high, pick the winner: if both are high, the winner is !last; otherwise the single requester.
  - On the next edge: gnt=onehot(winner), busy=1, CS=0, shift register loaded with wdata[winner], MOSI=wdata[winner][7], last=winner; go to SETUP.
- SETUP: hold CLK_DIV cycles, SCLK=0; then go to SHI.
- SHI:
  - On entry, SCLK=1 and MISO is shifted into the rx register (sampled at the same clk edge that raises SCLK).
  - Hold CLK_DIV cycles, then go to SLO.
- SLO:
  - On entry, SCLK=0. If bit<7, MOSI=next bit and bit++.
  - Hold CLK_DIV cycles. If bit<7, go to SHI.
  - After the 8th low phase, on the next edge: CS=1, gnt=0, done=1, done_id=last, rdata=rx; go to GAP.
- Frame timing: CS low for exactly 17*CLK_DIV cycles, containing 8 SCLK rising edges.
- GAP: CS=1 for CS_GAP cycles, busy=1. Then IDLE with busy=0; arbitration can fire in the same cycle as the return to IDLE.
- Inputs during a frame:
  - req deassert mid-frame is ignored; the frame completes and done still pulses.
  - wdata changes after the grant are ignored.
- Back-to-back: if the same requester keeps req high and the other is idle, it is regranted after the gap. If both are high, grants alternate.
- No requests: IDLE is stable; outputs stay at their idle values.

Optional Feature:
- SPI_LOOPBACK_EN defined: the internal sample source is MOSI instead of the MISO pin, so rdata equals the transmitted byte. MISO is ignored. Intended for board bring-up.
- Undefined: samples the MISO pin as above.

Decomposition:
- Package spi_ctrl_pkg:
  - FSM state enum (IDLE/SETUP/SHI/SLO/GAP).
  - SPI_W=8.
  - NREQ=2.
- Sub-module spi_rr_arbiter: combinational winner from req plus the last pointer, registered in the parent on grant.
- The SCLK/shift datapath stays in spi_master_arb.

Test Plan:
- Single frame, CLK_DIV=2, with a slave model returning 0x3C; req=01, wdata0=0xA5 -> CS low 34 cycles, MOSI sequence 1,0,1,0,0,1,0,1 at SCLK rises, done=1 with done_id=0 and rdata=0x3C.
- Both requesting: req=11, wdata0=0x11, wdata1=0x22 -> grants in order 0,1,0,1; each done_id matches; frames separated by ≥CS_GAP cycles of CS=1.
- Requester 0 drops req at bit 3 -> frame completes, done pulses once, no further grant to 0.
- Reset asserted at the 4th SCLK high -> next cycle CS=1, SCLK=0, gnt=0, no done; after release a pending req=10 grants requester 1 (last=1, so requester 1 wins only if requester 0 is absent).
- CLK_DIV=1, CS_GAP=1, requester 1 continuous -> CS low 17 cycles, high 1 cycle, repeating; rdata tracks the slave byte each frame.
- SPI_LOOPBACK_EN defined, wdata1=0xC3 -> rdata=0xC3 regardless of MISO held at 0.
